// File: rtl/tmds_period_scheduler.sv
// tmds_period_scheduler
//   Chooses the TMDS channel period for every pixel clock (control, video
//   preamble/guard band, active video, data-island preamble/guard/packet) and
//   arbitrates packet sources for data-island slots in horizontal blanking.
// Ports
//   clk       pixel clock
//   reset_n   asynchronous active-low reset
//   hcount    pixel counter 0..H_TOTAL-1 from the timing generator
//   vcount    line counter 0..V_TOTAL-1 from the timing generator
//   pkt_req   level request per packet source, held until granted
//   pkt_gnt   one-hot 1-clock grant: source owns the next 32-clock packet slot
//   period    0 CTRL,1 VID_PRE,2 VID_GB,3 VIDEO,4 DI_PRE,5 DI_GB_LEAD,6 DI_DATA,7 DI_GB_TRAIL
//   ctl       CTL3..0 for the encoders
//   pkt_word  word index 0..31 inside the current packet
//   pkt_first high on the first DI_DATA clock of an island
// All outputs are registered one clock after the hcount/vcount they describe.
module tmds_period_scheduler #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned DI_START = 660,
    parameter int unsigned MAX_PKT  = 2,
    parameter int unsigned N_SRC    = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [9:0]       hcount,
    input  logic [9:0]       vcount,
    input  logic [N_SRC-1:0] pkt_req,
    output logic [N_SRC-1:0] pkt_gnt,
    output logic [2:0]       period,
    output logic [3:0]       ctl,
    output logic [4:0]       pkt_word,
    output logic             pkt_first
);

    localparam int unsigned RRW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [9:0] HA      = 10'(H_ACTIVE);
    localparam logic [9:0] VA      = 10'(V_ACTIVE);
    localparam logic [9:0] VA_M1   = 10'(V_ACTIVE - 1);
    localparam logic [9:0] VT_M1   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HT_M1   = 10'(H_TOTAL - 1);
    localparam logic [9:0] HT_M2   = 10'(H_TOTAL - 2);
    localparam logic [9:0] HT_M3   = 10'(H_TOTAL - 3);
    localparam logic [9:0] HT_M10  = 10'(H_TOTAL - 10);
    localparam logic [9:0] DI_H    = 10'(DI_START);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_GB_LEAD, S_DATA, S_GB_TRAIL
    } di_state_e;

    typedef enum logic [2:0] {
        P_CTRL = 3'd0, P_VID_PRE = 3'd1, P_VID_GB = 3'd2, P_VIDEO = 3'd3,
        P_DI_PRE = 3'd4, P_DI_GB_LEAD = 3'd5, P_DI_DATA = 3'd6, P_DI_GB_TRAIL = 3'd7
    } period_e;

    di_state_e        st_q, st_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       npk_q, npk_d;
    logic [1:0]       pidx_q, pidx_d;
    logic [RRW-1:0]   rr_q, rr_d;
    logic [9:0]       hprev_q, hprev_d;
    period_e          period_q, period_d;
    logic [3:0]       ctl_q, ctl_d;
    logic [N_SRC-1:0] pkt_gnt_q, pkt_gnt_d;
    logic [4:0]       pkt_word_q, pkt_word_d;
    logic             pkt_first_q, pkt_first_d;

    logic [2:0]       pop;
    logic [2:0]       npk_fit;
    logic [N_SRC-1:0] arb_gnt;
    logic [RRW-1:0]   arb_rr;
    logic             arb_found;
    logic             nlv;
    logic             h_cont;
    logic [9:0]       h_exp;
    logic             last_pkt;

    // Packets in the island: requesters capped at MAX_PKT, then trimmed so the
    // island still ends before the video preamble.
    always_comb begin
        pop     = '0;
        npk_fit = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            pop = pop + 3'(pkt_req[i]);
        end
        for (int unsigned n = 1; n <= MAX_PKT; n++) begin
            if ((3'(n) <= pop) && (DI_START + 12 + 32 * n <= H_TOTAL - 10)) begin
                npk_fit = 3'(n);
            end
        end
    end

    // Round-robin: first live requester at or after the pointer.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        arb_gnt   = '0;
        arb_rr    = rr_q;
        arb_found = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            idx = (int'(rr_q) + i) % N_SRC;
            if (!arb_found && pkt_req[idx]) begin
                arb_found    = 1'b1;
                arb_gnt[idx] = 1'b1;
                arb_rr       = RRW'((idx + 1) % N_SRC);
            end
        end
    end

    assign nlv      = (vcount == VT_M1) || (vcount < VA_M1);
    assign h_exp    = (hprev_q == HT_M1) ? '0 : hprev_q + 10'd1;
    assign h_cont   = (hcount == h_exp);
    assign last_pkt = ({1'b0, pidx_q} == (npk_q - 3'd1));

    always_comb begin
        st_d        = st_q;
        cnt_d       = cnt_q;
        npk_d       = npk_q;
        pidx_d      = pidx_q;
        rr_d        = rr_q;
        hprev_d     = hcount;
        pkt_gnt_d   = '0;
        pkt_word_d  = '0;
        pkt_first_d = 1'b0;
        period_d    = P_CTRL;
        ctl_d       = '0;

        case (st_q)
            S_IDLE: begin
                if ((hcount == DI_H) && (npk_fit != '0)) begin
                    st_d  = S_PRE;
                    cnt_d = '0;
                    npk_d = npk_fit;
                end
            end
            S_PRE: begin
                if (cnt_q == 3'd7) begin
                    st_d  = S_GB_LEAD;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_GB_LEAD: begin
                if (cnt_q == 3'd0) begin
                    // Entering the last guard clock: first slot is granted here.
                    cnt_d     = 3'd1;
                    pkt_gnt_d = arb_gnt;
                    rr_d      = arb_rr;
                end else begin
                    st_d        = S_DATA;
                    pidx_d      = '0;
                    pkt_first_d = 1'b1;
                end
            end
            S_DATA: begin
                pkt_word_d = pkt_word_q + 5'd1;
                if (pkt_word_q == 5'd31) begin
                    if (last_pkt) begin
                        st_d  = S_GB_TRAIL;
                        cnt_d = '0;
                    end else begin
                        pidx_d = pidx_q + 2'd1;
                    end
                end
                // Word 31 of a non-final packet grants the following slot.
                if ((pkt_word_q == 5'd30) && !last_pkt) begin
                    pkt_gnt_d = arb_gnt;
                    rr_d      = arb_rr;
                end
            end
            S_GB_TRAIL: begin
                if (cnt_q == 3'd1) begin
                    st_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: st_d = S_IDLE;
        endcase

        // Video timing owns the line end; a broken hcount sequence also kills
        // the island. A suppressed grant must not advance the pointer.
        if ((st_q != S_IDLE) && (!h_cont || (hcount >= HT_M10))) begin
            st_d        = S_IDLE;
            pkt_gnt_d   = '0;
            pkt_first_d = 1'b0;
            rr_d        = rr_q;
        end

        if (st_d != S_DATA) begin
            pkt_word_d = '0;
        end

        case (st_d)
            S_PRE:      period_d = P_DI_PRE;
            S_GB_LEAD:  period_d = P_DI_GB_LEAD;
            S_DATA:     period_d = P_DI_DATA;
            S_GB_TRAIL: period_d = P_DI_GB_TRAIL;
            default:    period_d = P_CTRL;
        endcase

        if (nlv && (hcount >= HT_M10) && (hcount <= HT_M3)) begin
            period_d = P_VID_PRE;
        end else if (nlv && (hcount >= HT_M2)) begin
            period_d = P_VID_GB;
        end else if ((hcount < HA) && (vcount < VA)) begin
            period_d = P_VIDEO;
        end

        if (period_d == P_VID_PRE) begin
            ctl_d = 4'b0001;
        end else if (period_d == P_DI_PRE) begin
            ctl_d = 4'b0101;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q        <= S_IDLE;
            cnt_q       <= '0;
            npk_q       <= '0;
            pidx_q      <= '0;
            rr_q        <= '0;
            hprev_q     <= '0;
            period_q    <= P_CTRL;
            ctl_q       <= '0;
            pkt_gnt_q   <= '0;
            pkt_word_q  <= '0;
            pkt_first_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            npk_q       <= npk_d;
            pidx_q      <= pidx_d;
            rr_q        <= rr_d;
            hprev_q     <= hprev_d;
            period_q    <= period_d;
            ctl_q       <= ctl_d;
            pkt_gnt_q   <= pkt_gnt_d;
            pkt_word_q  <= pkt_word_d;
            pkt_first_q <= pkt_first_d;
        end
    end

    assign period    = period_q;
    assign ctl       = ctl_q;
    assign pkt_gnt   = pkt_gnt_q;
    assign pkt_word  = pkt_word_q;
    assign pkt_first = pkt_first_q;

endmodule

// File: tb/tb_tmds_period_scheduler.sv
// tb_tmds_period_scheduler
//   Drives selected 800-pixel lines into a default scheduler and a second one
//   whose island start is too late to fit. A reference model pushes expected
//   outputs per driven pixel; they are popped and compared one clock later.
module tb_tmds_period_scheduler;

    localparam int DI_MAIN = 660;
    localparam int DI_LATE = 760;
    localparam int MAXP    = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] hcount = '0;
    logic [9:0] vcount = '0;
    logic [1:0] pkt_req = '0;

    logic [1:0] pkt_gnt, pkt_gnt_l;
    logic [2:0] period, period_l;
    logic [3:0] ctl, ctl_l;
    logic [4:0] pkt_word, pkt_word_l;
    logic       pkt_first, pkt_first_l;

    tmds_period_scheduler u_dut (
        .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .pkt_req(pkt_req), .pkt_gnt(pkt_gnt), .period(period), .ctl(ctl),
        .pkt_word(pkt_word), .pkt_first(pkt_first)
    );

    tmds_period_scheduler #(.DI_START(DI_LATE)) u_dut_late (
        .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .pkt_req(pkt_req), .pkt_gnt(pkt_gnt_l), .period(period_l), .ctl(ctl_l),
        .pkt_word(pkt_word_l), .pkt_first(pkt_first_l)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] period;
        logic [3:0] ctl;
        logic [1:0] gnt;
        logic [4:0] word;
        logic       first;
    } exp_t;

    typedef struct {
        bit on;
        int s;
        int n;
        int rr;
        int prev;
    } mstate_t;

    typedef struct {
        int         v;
        logic [1:0] req;
        int         drop_h;
        int         jump_from;
        int         jump_to;
        int         reset_h;
    } line_t;

    exp_t    sb[$];
    exp_t    sb_late[$];
    mstate_t ms_m, ms_l;
    logic [1:0] req_m;
    logic [1:0] req_l;
    int n_checks = 0;
    int n_fail   = 0;
    int vid_cnt  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Island described by its start pixel and packet count; everything else
    // follows from the offset of the current pixel from that start.
    task automatic model_step(input int di_start, input int h, input int v,
                              inout mstate_t ms, inout logic [1:0] req, output exp_t e);
        int  n, off, idx;
        bit  nlv, done;
        e   = '0;
        nlv = (v == 524) || (v < 479);
        if (ms.on && (h != (ms.prev + 1) % 800)) ms.on = 0;
        if (h >= 790) ms.on = 0;
        if (ms.on && (h - ms.s >= 12 + 32 * ms.n)) ms.on = 0;
        if (!ms.on && h == di_start && req != 2'b00) begin
            n = $countones(req);
            if (n > MAXP) n = MAXP;
            while (n > 0 && di_start + 12 + 32 * n > 790) n--;
            if (n > 0) begin
                ms.on = 1;
                ms.s  = h;
                ms.n  = n;
            end
        end
        if (ms.on) begin
            off = h - ms.s;
            if (off < 8) e.period = 3'd4;
            else if (off < 10) e.period = 3'd5;
            else if (off < 10 + 32 * ms.n) begin
                e.period = 3'd6;
                e.word   = 5'((off - 10) % 32);
                e.first  = (off == 10);
            end else e.period = 3'd7;
            if (off == 9 || (off >= 10 && off < 10 + 32 * (ms.n - 1) && (off - 10) % 32 == 31)) begin
                done = 0;
                for (int k = 0; k < 2; k++) begin
                    idx = (ms.rr + k) % 2;
                    if (!done && req[idx]) begin
                        done       = 1;
                        e.gnt[idx] = 1'b1;
                        ms.rr      = (idx + 1) % 2;
                        req[idx]   = 1'b0;
                    end
                end
            end
        end
        if (h >= 790 && h <= 797 && nlv) e.period = 3'd1;
        else if (h >= 798 && nlv) e.period = 3'd2;
        else if (h < 640 && v < 480) e.period = 3'd3;
        if (e.period == 3'd1) e.ctl = 4'b0001;
        else if (e.period == 3'd4) e.ctl = 4'b0101;
        ms.prev = h;
    endtask

    task automatic compare_pending();
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("period", 32'(period), 32'(e.period));
            check_eq("ctl", 32'(ctl), 32'(e.ctl));
            check_eq("pkt_gnt", 32'(pkt_gnt), 32'(e.gnt));
            check_eq("pkt_word", 32'(pkt_word), 32'(e.word));
            check_eq("pkt_first", 32'(pkt_first), 32'(e.first));
            if (period == 3'd3) vid_cnt++;
        end
        if (sb_late.size() != 0) begin
            e = sb_late.pop_front();
            check_eq("late_period", 32'(period_l), 32'(e.period));
            check_eq("late_gnt", 32'(pkt_gnt_l), 32'(e.gnt));
        end
    endtask

    task automatic cycle(input int h, input int v, input bit rst_now);
        exp_t e, el;
        @(negedge clk);
        compare_pending();
        if (rst_now) begin
            reset_n = 1'b0;
            #1;
            check_eq("rst_async_period", 32'(period), 32'd0);
            check_eq("rst_async_gnt", 32'(pkt_gnt), 32'd0);
            check_eq("rst_async_word", 32'(pkt_word), 32'd0);
            check_eq("rst_async_ctl", 32'(ctl), 32'd0);
            sb.delete();
            sb_late.delete();
            ms_m  = '{default: 0};
            ms_l  = '{default: 0};
            req_m = '0;
        end
        hcount  = 10'(h);
        vcount  = 10'(v);
        pkt_req = req_m;
        if (!reset_n) begin
            e  = '0;
            el = '0;
        end else begin
            req_l = req_m;
            model_step(DI_MAIN, h, v, ms_m, req_m, e);
            model_step(DI_LATE, h, v, ms_l, req_l, el);
        end
        sb.push_back(e);
        sb_late.push_back(el);
    endtask

    line_t plan[9] = '{
        '{523, 2'b00, -1, -1, -1, -1},   // blank line, no preamble at the end
        '{524, 2'b01, -1, -1, -1, -1},   // single packet, preamble at line end
        '{0,   2'b11, -1, -1, -1, -1},   // two packets, pointer starts at 1
        '{1,   2'b11, -1, -1, -1, -1},
        '{2,   2'b11, 680, -1, -1, -1},  // requests withdrawn before 2nd grant
        '{478, 2'b01, -1, 690, 750, -1}, // hcount jump aborts island
        '{479, 2'b11, -1, -1, -1, 681},  // reset during DATA word 10
        '{480, 2'b01, -1, -1, -1, -1},   // clean island after reset
        '{481, 2'b10, -1, -1, -1, -1}
    };

    initial begin
        int h;
        ms_m  = '{default: 0};
        ms_l  = '{default: 0};
        req_m = '0;
        req_l = '0;
        for (int i = 796; i < 800; i++) cycle(i, 522, 1'b0);
        check_eq("rst_period", 32'(period), 32'd0);
        check_eq("rst_gnt", 32'(pkt_gnt), 32'd0);
        check_eq("rst_first", 32'(pkt_first), 32'd0);
        @(negedge clk);
        compare_pending();
        reset_n = 1'b1;
        for (int l = 0; l < 9; l++) begin
            h = 0;
            while (h < 800) begin
                if (h == 0) req_m = plan[l].req;
                if (h == plan[l].drop_h) req_m = '0;
                if (plan[l].reset_h >= 0 && h == plan[l].reset_h + 3) reset_n = 1'b1;
                cycle(h, plan[l].v, (h == plan[l].reset_h));
                h = (h == plan[l].jump_from) ? plan[l].jump_to : h + 1;
            end
        end
        @(negedge clk);
        compare_pending();
        check_eq("video_clk_count", 32'(vid_cnt), 32'(5 * 640));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
